fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch stage of the SPORK core, directly upstream of instROM. It drives the ROM's 16-bit InstAddress, captures the 9-bit instruction the ROM returns into a fetch/decode pipeline register, and presents it to the decoder with a valid flag and its own PC. It applies sequential increment, PC-relative branches, absolute jumps, stalls and halt/restart under a three-state control FSM.

## Interface
- PC_W, 16, program counter and ROM address width
- INST_W, 9, instruction width
- OFF_W, 8, signed branch offset width
- START_ADDR, 16'h0000, PC loaded at reset and on restart

- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  pulse; leaves IDLE or HALT and begins fetching at START_ADDR
- Stall  in  1  holds the PC and the D-stage register
- Halt  in  1  decoder has decoded a halt instruction in D
- BranchTaken  in  1  take the PC-relative branch for the instruction in D
- BranchOffset  in  OFF_W  signed offset, relative to InstPC
- JumpEn  in  1  absolute jump for the instruction in D
- JumpTarget  in  PC_W  absolute jump address
- InstAddress  out  PC_W  fetch PC, drives instROM InstAddress
- InstIn  in  INST_W  instROM InstOut, combinational from InstAddress
- InstOut  out  INST_W  registered instruction (D stage)
- InstPC  out  PC_W  address of InstOut
- InstValid  out  1  InstOut is a live instruction
- Halted  out  1  FSM is in HALT

## Operation
- FSM states:
  - IDLE: the reset state. Stays here until Start.
  - RUN: fetching. Enters HALT on Halt.
  - HALT: stopped. Start returns it to RUN.
- Entering RUN from either IDLE or HALT: PC <= START_ADDR and the D stage is cleared.
- Two-stage pipeline:
  - F: InstAddress = PC.
  - D: each advancing cycle loads InstOut <= InstIn and InstPC <= PC.
- Next-PC priority, evaluated in RUN only:
  1. Halt
  2. Stall
  3. JumpEn
  4. BranchTaken
  5. PC+1
- Halt (with InstValid=1): the PC is frozen and InstValid goes to 0 next cycle. A simultaneous Jump or Branch is ignored.
- Stall: the PC, InstOut, InstPC and InstValid all hold. Redirect inputs are ignored while Stall=1.
- JumpEn: PC <= JumpTarget.
- BranchTaken: PC <= InstPC + sign_extend(BranchOffset).
- A redirect squashes the F-stage instruction: InstValid=0 on the next cycle, giving exactly one bubble.
- Redirect and Halt inputs are only honoured when InstValid=1. They are ignored on a bubble.
- Arithmetic is modulo 2^PC_W. 16'hFFFF+1 wraps to 16'h0000. Branch targets wrap in both directions.
- In IDLE and HALT:
  - InstValid=0.
  - The PC holds.
  - InstOut and InstPC hold their last values.
- Start while in RUN is ignored.
- Reset mid-operation returns to IDLE immediately, asynchronously, from any state.

## Timing
- Reset values:
  - state=IDLE, PC=START_ADDR, InstAddress=START_ADDR.
  - InstOut=0, InstPC=0, InstValid=0, Halted=0.
  - The perf counter (if compiled in) is 0.
- Start in cycle N: PC=START_ADDR at the edge ending N. InstValid=1 with InstPC=START_ADDR from cycle N+2.
- Fetch-to-D latency is 1 cycle. Sustained throughput is 1 instruction per cycle.
- Redirect sampled at edge E: the target is on InstAddress after E. The target instruction is in D after E+1, and InstValid=0 for one cycle in between.
- Halt sampled at edge E: Halted=1 and InstValid=0 after E.

## Configuration
- FETCH_PERF_CNT_EN:
  - Defined: adds output FetchCount (32 bits, out). It increments once per cycle in which InstValid=1 and Stall=0. It resets to 0 on Reset_n and on every Start, and saturates at 32'hFFFF_FFFF.
  - Undefined: the port and the counter are absent.

## Structure
- Shared package spork_pkg holds:
  - PC_W and INST_W constants.
  - typedef pc_t (logic[PC_W-1:0]) and inst_t (logic[INST_W-1:0]).
  - enum fetch_state_t {IDLE, RUN, HALT}.
- One sub-module, fetch_next_pc: combinational priority mux plus branch adder, producing the next PC.

## Test plan
- Reset, then Start with instROM attached:
  - After reset: InstAddress=0, InstValid=0, Halted=0.
  - After Start: InstPC=0,1,2,3 on consecutive cycles, each InstOut matching ROM[InstPC].
- Branch: BranchTaken with BranchOffset=-4 while InstPC=10 -> one bubble (InstValid=0), then InstPC=6,7,8.
- Jump: JumpEn with JumpTarget=16'h0020 while InstPC=5 -> one bubble, then InstPC=16'h0020.
- Stall for 3 cycles at InstPC=7 -> InstPC, InstOut and InstAddress held for 3 cycles. A BranchTaken during the stall is ignored. After release, InstPC=8.
- Halt at InstPC=12:
  - Halted=1 and InstValid=0 next cycle; the PC is frozen.
  - Start then gives InstPC=0 two cycles later.
  - Reset_n asserted mid-RUN forces IDLE asynchronously.
- Wrap and counter:
  - Jump to 16'hFFFE -> InstPC=16'hFFFE, 16'hFFFF, 16'h0000.
  - With FETCH_PERF_CNT_EN defined: FetchCount equals the number of valid, unstalled cycles.

Source files
------------

// File: rtl/spork_pkg.sv
// spork_pkg: shared widths, types and fetch FSM states for the SPORK core
package spork_pkg;
  localparam int PC_W = 16;
  localparam int INST_W = 9;
  typedef logic [PC_W-1:0] pc_t;
  typedef logic [INST_W-1:0] inst_t;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: next-PC priority mux (hold > jump > branch > increment) with branch adder
// ports: pc/inst_pc/jump_target/branch_offset in, hold/jump/branch selects in, next_pc out
module fetch_next_pc import spork_pkg::*; #(
  parameter int OFF_W = 8
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  inst_pc,
  input  logic [PC_W-1:0]  jump_target,
  input  logic [OFF_W-1:0] branch_offset,
  input  logic             hold,
  input  logic             jump,
  input  logic             branch,
  output logic [PC_W-1:0]  next_pc
);
  always_comb next_pc = hold ? pc : jump ? jump_target : branch ? inst_pc + {{(PC_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset} : pc + 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: SPORK PC and fetch stage feeding instROM, with F/D pipeline register and IDLE/RUN/HALT control
// ports: Clk, Reset_n (async, active-low); Start/Stall/Halt/BranchTaken/BranchOffset/JumpEn/JumpTarget control in;
//        InstAddress to ROM, InstIn from ROM; InstOut/InstPC/InstValid to decoder; Halted status
// FETCH_PERF_CNT_EN adds FetchCount, a saturating count of valid unstalled cycles
module fetch_unit import spork_pkg::*; #(
  parameter int              OFF_W      = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              BranchTaken,
  input  logic [OFF_W-1:0]  BranchOffset,
  input  logic              JumpEn,
  input  logic [PC_W-1:0]   JumpTarget,
  output logic [PC_W-1:0]   InstAddress,
  input  logic [INST_W-1:0] InstIn,
  output logic [INST_W-1:0] InstOut,
  output logic [PC_W-1:0]   InstPC,
  output logic              InstValid,
  output logic              Halted
`ifdef FETCH_PERF_CNT_EN
  , output logic [31:0]     FetchCount
`endif
);
  fetch_state_t state, state_nx;
  logic [PC_W-1:0] pc, pc_nx;
  logic halt_v, redir;
  // control inputs only apply to a live instruction in D
  assign halt_v = Halt & InstValid;
  assign redir = InstValid & (JumpEn | BranchTaken);
  assign InstAddress = pc;
  assign Halted = state == HALT;
  fetch_next_pc #(.OFF_W(OFF_W)) u_next (
    .pc(pc),
    .inst_pc(InstPC),
    .jump_target(JumpTarget),
    .branch_offset(BranchOffset),
    .hold(halt_v | Stall),
    .jump(InstValid & JumpEn),
    .branch(InstValid & BranchTaken),
    .next_pc(pc_nx)
  );
  always_comb begin
    state_nx = state;
    state_nx = state != RUN ? (Start ? RUN : state) : (halt_v ? HALT : RUN);
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      pc <= START_ADDR;
      InstOut <= '0;
      InstPC <= '0;
      InstValid <= 1'b0;
    end else if (state != RUN) begin
      if (Start) begin
        pc <= START_ADDR;
        InstValid <= 1'b0;
      end
    end else if (halt_v) begin
      InstValid <= 1'b0;
    end else if (!Stall) begin
      pc <= pc_nx;
      InstOut <= InstIn;
      InstPC <= pc;
      // the instruction fetched alongside a redirect is on the wrong path
      InstValid <= !redir;
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) FetchCount <= '0;
    else if (Start) FetchCount <= '0;
    else if (InstValid && !Stall && !(&FetchCount)) FetchCount <= FetchCount + 1'b1;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a modelled instROM
module tb_fetch_unit;
  logic Clk = 1'b0;
  logic Reset_n;
  logic Start = 1'b0, Stall = 1'b0, Halt = 1'b0, BranchTaken = 1'b0, JumpEn = 1'b0;
  logic [7:0] BranchOffset = '0;
  logic [15:0] JumpTarget = '0;
  logic [15:0] InstAddress, InstPC;
  logic [8:0] InstIn, InstOut;
  logic InstValid, Halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount, exp_cnt;
`endif
  int checks = 0, errors = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_pc;
  logic stall_q = 1'b0;

  always #5 Clk = ~Clk;

  function automatic logic [8:0] rom(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'd37 + 16'd5;
    return t[8:0] ^ a[15:7];
  endfunction

  assign InstIn = rom(InstAddress);

  fetch_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchTaken(BranchTaken), .BranchOffset(BranchOffset), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .InstAddress(InstAddress), .InstIn(InstIn), .InstOut(InstOut), .InstPC(InstPC),
    .InstValid(InstValid), .Halted(Halted)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(FetchCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_pc(input logic [15:0] t);
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (InstValid && InstPC == t) return;
    end
    check("wait_pc", {15'b0, InstValid, InstPC}, {15'b0, 1'b1, t});
  endtask

  task automatic redirect(input logic jump, input logic [15:0] tgt, input logic [7:0] off, input logic [15:0] exp_addr);
    JumpEn = jump;
    BranchTaken = !jump;
    JumpTarget = tgt;
    BranchOffset = off;
    @(posedge Clk);
    #1 JumpEn = 1'b0;
    BranchTaken = 1'b0;
    @(negedge Clk);
    check("redir_bubble", InstValid, 0);
    check("redir_addr", InstAddress, exp_addr);
  endtask

  always @(posedge Clk) stall_q <= Stall;

  // a new instruction reaches D whenever it is valid and the previous edge was not a stall
  always @(negedge Clk)
    if (Reset_n && InstValid && !stall_q) begin
      if (sb.size() == 0) check("sb_extra", InstPC, 32'hDEAD_BEEF);
      else begin
        exp_pc = sb.pop_front();
        check("sb_pc", InstPC, exp_pc);
        check("sb_inst", InstOut, rom(exp_pc));
      end
    end

`ifdef FETCH_PERF_CNT_EN
  always @(posedge Clk or negedge Reset_n)
    if (!Reset_n) exp_cnt <= 0;
    else if (Start) exp_cnt <= 0;
    else if (InstValid && !Stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt <= exp_cnt + 1;
`endif

  initial begin
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_addr", InstAddress, 0);
    check("rst_valid", InstValid, 0);
    check("rst_halted", Halted, 0);
    check("rst_instpc", InstPC, 0);
    check("rst_instout", InstOut, 0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_cnt", FetchCount, 0);
`endif
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    check("idle_valid", InstValid, 0);
    check("idle_addr", InstAddress, 0);
    for (int i = 0; i <= 5; i++) sb.push_back(16'(i));
    sb.push_back(16'h20);
    sb.push_back(16'h21);
    sb.push_back(16'd9);
    sb.push_back(16'd10);
    sb.push_back(16'd6);
    sb.push_back(16'd7);
    for (int i = 8; i <= 12; i++) sb.push_back(16'(i));
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("start_valid", InstValid, 0);
    check("start_addr", InstAddress, 0);
    wait_pc(16'd5);
    redirect(1'b1, 16'h20, 8'h00, 16'h20);
    wait_pc(16'h21);
    redirect(1'b1, 16'd9, 8'h00, 16'd9);
    wait_pc(16'd10);
    redirect(1'b0, 16'h0, 8'hFC, 16'd6);
    wait_pc(16'd7);
    Stall = 1'b1;
    BranchTaken = 1'b1;
    BranchOffset = 8'h10;
    repeat (3) begin
      @(negedge Clk);
      check("stall_pc", InstPC, 7);
      check("stall_inst", InstOut, rom(16'd7));
      check("stall_addr", InstAddress, 8);
      check("stall_valid", InstValid, 1);
    end
    Stall = 1'b0;
    BranchTaken = 1'b0;
    wait_pc(16'd12);
    Halt = 1'b1;
    JumpEn = 1'b1;
    JumpTarget = 16'h40;
    @(posedge Clk);
    #1 Halt = 1'b0;
    JumpEn = 1'b0;
    @(negedge Clk);
    check("halt_halted", Halted, 1);
    check("halt_valid", InstValid, 0);
    check("halt_addr", InstAddress, 13);
    repeat (2) begin
      @(negedge Clk);
      check("halt_hold_addr", InstAddress, 13);
      check("halt_hold_valid", InstValid, 0);
    end
`ifdef FETCH_PERF_CNT_EN
    check("cnt_run1", FetchCount, exp_cnt);
`endif
    sb.push_back(16'd0);
    sb.push_back(16'd1);
    sb.push_back(16'd2);
    sb.push_back(16'hFFFE);
    sb.push_back(16'hFFFF);
    sb.push_back(16'd0);
    sb.push_back(16'd1);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("restart_halted", Halted, 0);
    check("restart_valid0", InstValid, 0);
    check("restart_addr", InstAddress, 0);
    @(negedge Clk);
    check("restart_pc", InstPC, 0);
    check("restart_valid1", InstValid, 1);
    wait_pc(16'd2);
    redirect(1'b1, 16'hFFFE, 8'h00, 16'hFFFE);
    wait_pc(16'hFFFF);
    wait_pc(16'd1);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_run2", FetchCount, exp_cnt);
`endif
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_valid", InstValid, 0);
    check("async_rst_addr", InstAddress, 0);
    check("async_rst_halted", Halted, 0);
`ifdef FETCH_PERF_CNT_EN
    check("async_rst_cnt", FetchCount, 0);
`endif
    @(negedge Clk);
    check("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
